// File: rtl/tile_judge_pkg.sv
// tile_judge_pkg: shared game-state type, lane key map and screen geometry for the tile judge.
package tile_judge_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t;
    localparam int          N_LANES   = 4;
    localparam int          SPAWN_MIN = 8;
    localparam logic [7:0]  LANE_KEY [N_LANES] = '{8'h04, 8'h16, 8'h07, 8'h09};
    localparam logic [7:0]  KEY_START    = 8'h2C;
    localparam logic [10:0] HIT_Y_MIN    = 11'd280;
    localparam logic [10:0] HIT_Y_MAX    = 11'd403;
    localparam logic [10:0] SCREEN_Y_MAX = 11'd479;
    localparam logic [10:0] TILE_SIZE    = 11'd75;
endpackage

// File: rtl/tile_judge_if.sv
// tile_judge_if: bundle between the judge (master) and the tile lanes / key source (slave).
//   keycode   : current USB keycode, 0 = no key
//   tile_y    : Y position of each lane's tile
//   newNote   : one-frame spawn pulse per lane
//   kill      : one-frame kill pulse per lane
//   speed     : tile speed, tile moves 3+speed px/frame
//   score     : saturating hit count
//   game_over : high in OVER
//   playing   : high in PLAY
interface tile_judge_if;
    import tile_judge_pkg::*;
    logic [7:0]              keycode;
    logic [N_LANES-1:0][9:0] tile_y;
    logic [N_LANES-1:0]      newNote;
    logic [N_LANES-1:0]      kill;
    logic [3:0]              speed;
    logic [15:0]             score;
    logic                    game_over;
    logic                    playing;
    modport master (input keycode, tile_y, output newNote, kill, speed, score, game_over, playing);
    modport slave (output keycode, tile_y, input newNote, kill, speed, score, game_over, playing);
endinterface

// File: rtl/tile_judge_lfsr.sv
// lane_lfsr: 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) picking candidate spawn lanes.
//   frame_clk : frame clock
//   Reset     : asynchronous active-high reset, loads SEED
//   en_i      : advance one step
//   lane_o    : low two bits of the state, used as the candidate lane
module lane_lfsr #(
    parameter logic [7:0] SEED = 8'hA5,
    parameter logic [7:0] TAPS = 8'hB8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       en_i,
    output logic [1:0] lane_o
);
    logic [7:0] lfsr_q, lfsr_d;
    assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? TAPS : 8'h00);
    assign lane_o = lfsr_q[1:0];
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)     lfsr_q <= SEED;
        else if (en_i) lfsr_q <= lfsr_d;
    end
endmodule

// File: rtl/tile_judge.sv
// tile_judge: falling-tile game controller; spawns tiles, judges key hits, scores, ends on a miss.
//   frame_clk : frame-rate clock (one edge per vsync)
//   Reset     : asynchronous active-high reset
//   bus       : tile_judge_if.master (keycode/tile_y in; newNote/kill/speed/score/game_over/playing out)
// Build option: define TILE_JUDGE_MISCLICK_EN to make a misclick end the game; otherwise it is ignored.
module tile_judge
    import tile_judge_pkg::*;
#(
    parameter int SPAWN_FRAMES = 40,
    parameter int SPEED_STEP   = 8
) (
    input  logic         frame_clk,
    input  logic         Reset,
    tile_judge_if.master bus
);
    game_state_t        state_q, state_d;
    logic [7:0]         prev_key_q, cnt_q, cnt_d, thr;
    logic [N_LANES-1:0] active_q, active_d, armed_q, armed_d, arm_pipe_q;
    logic [N_LANES-1:0] newNote_q, newNote_d, kill_q, kill_d, key_hit, hit_l, miss_l;
    logic [3:0]         speed_q, speed_d;
    logic [15:0]        score_q, score_d, level;
    logic [1:0]         cand, spawn_lane;
    logic               press, start, miss, end_game, found;

    lane_lfsr u_lfsr (.frame_clk, .Reset, .en_i(1'b1), .lane_o(cand));

    assign press = bus.keycode != prev_key_q && bus.keycode != 8'h00;
    assign start = press && bus.keycode == KEY_START;
    assign level = score_q / 16'(SPEED_STEP);
    // Spawn period shrinks by two frames per speed step but never below SPAWN_MIN.
    assign thr = (8'(SPAWN_FRAMES) > {3'b0, speed_q, 1'b0} + 8'(SPAWN_MIN))
                 ? 8'(SPAWN_FRAMES) - {3'b0, speed_q, 1'b0} : 8'(SPAWN_MIN);

    always_comb begin
        key_hit = '0;
        hit_l   = '0;
        miss_l  = '0;
        for (int l = 0; l < N_LANES; l++) begin
            key_hit[l] = press && bus.keycode == LANE_KEY[l];
            hit_l[l]   = key_hit[l] && active_q[l] && armed_q[l]
                         && {1'b0, bus.tile_y[l]} >= HIT_Y_MIN && {1'b0, bus.tile_y[l]} <= HIT_Y_MAX;
            miss_l[l]  = active_q[l] && armed_q[l] && {1'b0, bus.tile_y[l]} + TILE_SIZE >= SCREEN_Y_MAX;
        end
    end
    assign miss = |miss_l;

`ifdef TILE_JUDGE_MISCLICK_EN
    logic misclick;
    assign misclick = |(key_hit & ~hit_l);
    assign end_game = miss | misclick;
`else
    assign end_game = miss;
`endif

    // First free lane at or after the LFSR candidate, wrapping mod 4.
    always_comb begin
        spawn_lane = cand;
        found      = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            if (!found && !active_q[cand + 2'(i)]) begin
                spawn_lane = cand + 2'(i);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        armed_d   = armed_q | arm_pipe_q;
        newNote_d = '0;
        kill_d    = '0;
        score_d   = score_q;
        speed_d   = level > 16'd15 ? 4'd15 : level[3:0];
        case (state_q)
            IDLE: if (start) begin
                state_d  = PLAY;
                cnt_d    = '0;
                active_d = '0;
                armed_d  = '0;
                score_d  = '0;
                speed_d  = '0;
            end
            PLAY: if (end_game) state_d = OVER;
            else begin
                kill_d   = hit_l;
                active_d = active_q & ~hit_l;
                if (|hit_l && score_q != 16'hFFFF) score_d = score_q + 16'd1;
                if (cnt_q + 8'd1 >= thr) begin
                    // With every lane busy, park at the terminal count so the next frame retries.
                    cnt_d = found ? 8'd0 : thr - 8'd1;
                    if (found) begin
                        newNote_d[spawn_lane] = 1'b1;
                        active_d[spawn_lane]  = 1'b1;
                        armed_d[spawn_lane]   = 1'b0;
                    end
                end else cnt_d = cnt_q + 8'd1;
            end
            OVER: if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // arm_pipe delays arming by two frames: the tile only sees the pulse a frame after we raise it.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            prev_key_q <= '0;
            cnt_q      <= '0;
            active_q   <= '0;
            armed_q    <= '0;
            arm_pipe_q <= '0;
            newNote_q  <= '0;
            kill_q     <= '0;
            speed_q    <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            prev_key_q <= bus.keycode;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            armed_q    <= armed_d;
            arm_pipe_q <= newNote_q;
            newNote_q  <= newNote_d;
            kill_q     <= kill_d;
            speed_q    <= speed_d;
            score_q    <= score_d;
        end
    end

    assign bus.newNote   = newNote_q;
    assign bus.kill      = kill_q;
    assign bus.speed     = speed_q;
    assign bus.score     = score_q;
    assign bus.game_over = state_q == OVER;
    assign bus.playing   = state_q == PLAY;
endmodule

// File: tb/tb_tile_judge.sv
// tb_tile_judge: directed self-checking bench for tile_judge.
module tb_tile_judge;
    import tile_judge_pkg::*;
    logic frame_clk = 1'b0;
    logic Reset;
    int   tests = 0, fails = 0;

    tile_judge_if bus();
    tile_judge dut (.frame_clk(frame_clk), .Reset(Reset), .bus(bus));

    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] mask, seen, nn, active_tb, spd_exp;
    int         k, spawns, exp_score, sel;
    int         rdy [4];
    bit         pressed, spd_pending, pick;
    string      spd_tag;

    initial begin
        Reset       = 1'b1;
        bus.keycode = 8'h00;
        bus.tile_y  = {4{10'd100}};
        tick();
        chk("rst_newNote", bus.newNote, 0);
        chk("rst_kill", bus.kill, 0);
        chk("rst_speed", bus.speed, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_game_over", bus.game_over, 0);
        chk("rst_playing", bus.playing, 0);
        Reset = 1'b0;
        repeat (3) tick();
        chk("idle_playing", bus.playing, 0);

        // start and first spawn
        bus.keycode = KEY_START;
        tick();
        chk("start_playing", bus.playing, 1);
        bus.keycode = 8'h00;
        k = 0;
        nn = '0;
        while (k < 100 && nn == 0) begin
            tick();
            k++;
            nn = bus.newNote;
        end
        chk("first_spawn_delay", k, 40);
        chk("first_spawn_onehot", $countones(nn), 1);
        mask = nn;
        tick();
        chk("spawn_pulse_width", bus.newNote, 0);

        // fill all lanes, then nothing more spawns
        spawns = 1;
        k = 0;
        while (spawns < 4 && k < 400) begin
            tick();
            k++;
            if (bus.newNote != 0) begin
                chk("fill_new_lane", bus.newNote & mask, 0);
                mask |= bus.newNote;
                spawns++;
            end
        end
        chk("all_lanes_active", mask, 4'hF);
        seen = '0;
        repeat (60) begin
            tick();
            seen |= bus.newNote;
        end
        chk("full_no_spawn", seen, 0);

        // hit lane 0, key held for 5 frames
        bus.tile_y[0] = 10'd350;
        bus.keycode   = LANE_KEY[0];
        tick();
        chk("hit0_kill", bus.kill, 4'b0001);
        chk("hit0_score", bus.score, 1);
        tick();
        chk("kill_pulse_width", bus.kill, 0);
        chk("retry_next_frame", bus.newNote, 4'b0001);
        repeat (3) tick();
        chk("held_key_no_rehit", bus.score, 1);
        bus.keycode   = 8'h00;
        bus.tile_y[0] = 10'd100;
        tick();

        // kill lane 1, next spawn must go there
        bus.tile_y[1] = 10'd350;
        bus.keycode   = LANE_KEY[1];
        tick();
        chk("hit1_kill", bus.kill, 4'b0010);
        chk("hit1_score", bus.score, 2);
        bus.keycode = 8'h00;
        k = 0;
        nn = '0;
        while (k < 60 && nn == 0) begin
            tick();
            k++;
            nn = bus.newNote;
        end
        chk("respawn_lane1", nn, 4'b0010);

        // speed ramp: every lane sits in the hit window
        bus.tile_y  = {4{10'd350}};
        active_tb   = 4'hF;
        rdy         = '{0, 3, 0, 0};
        exp_score   = 2;
        pressed     = 1'b0;
        spd_pending = 1'b0;
        k = 0;
        while ((exp_score < 128 || pressed || spd_pending) && k < 20000) begin
            tick();
            k++;
            if (spd_pending) begin
                chk(spd_tag, bus.speed, spd_exp);
                spd_pending = 1'b0;
            end
            for (int l = 0; l < 4; l++) begin
                if (bus.newNote[l]) begin
                    active_tb[l] = 1'b1;
                    rdy[l] = k + 3;
                end
            end
            if (pressed) begin
                chk("score_step", bus.score, exp_score);
                bus.keycode = 8'h00;
                pressed = 1'b0;
                if (exp_score == 7)   begin spd_pending = 1'b1; spd_exp = 0;  spd_tag = "speed_at_7";   end
                if (exp_score == 8)   begin spd_pending = 1'b1; spd_exp = 1;  spd_tag = "speed_at_8";   end
                if (exp_score == 120) begin spd_pending = 1'b1; spd_exp = 15; spd_tag = "speed_at_120"; end
                if (exp_score == 128) begin spd_pending = 1'b1; spd_exp = 15; spd_tag = "speed_at_128"; end
            end else if (exp_score < 128) begin
                pick = 1'b0;
                sel  = 0;
                for (int l = 0; l < 4; l++) begin
                    if (!pick && active_tb[l] && k >= rdy[l]) begin
                        pick = 1'b1;
                        sel  = l;
                    end
                end
                if (pick) begin
                    bus.keycode    = LANE_KEY[sel];
                    active_tb[sel] = 1'b0;
                    exp_score++;
                    pressed = 1'b1;
                end
            end
        end
        chk("score_128", bus.score, 128);

        // miss on lane 2
        bus.tile_y = {4{10'd100}};
        k = 0;
        while (active_tb != 4'hF && k < 200) begin
            tick();
            k++;
            active_tb |= bus.newNote;
        end
        repeat (4) tick();
        bus.tile_y[2] = 10'd403;
        repeat (2) tick();
        chk("no_miss_at_403", bus.game_over, 0);
        bus.tile_y[2] = 10'd404;
        tick();
        chk("miss_game_over", bus.game_over, 1);
        chk("miss_not_playing", bus.playing, 0);
        seen = '0;
        repeat (10) begin
            tick();
            seen |= bus.newNote | bus.kill;
        end
        chk("over_no_pulses", seen, 0);
        chk("over_score_hold", bus.score, 128);
        chk("over_speed_hold", bus.speed, 15);

        // space -> IDLE, space -> PLAY
        bus.keycode = KEY_START;
        tick();
        chk("idle_game_over", bus.game_over, 0);
        chk("idle_playing2", bus.playing, 0);
        chk("idle_score_hold", bus.score, 128);
        bus.keycode = 8'h00;
        tick();
        bus.keycode = KEY_START;
        tick();
        chk("replay_playing", bus.playing, 1);
        chk("replay_score_clr", bus.score, 0);
        chk("replay_speed_clr", bus.speed, 0);
        bus.keycode = 8'h00;

        // misclick on lane 3 at y=100
        bus.tile_y = {4{10'd100}};
        mask = '0;
        k = 0;
        while (mask != 4'hF && k < 400) begin
            tick();
            k++;
            mask |= bus.newNote;
        end
        chk("refill_lanes", mask, 4'hF);
        repeat (4) tick();
        bus.keycode = 8'h05;
        tick();
        bus.keycode = 8'h00;
        tick();
        chk("nonlane_key_ignored", bus.playing, 1);
        bus.keycode = LANE_KEY[3];
        tick();
        bus.keycode = 8'h00;
`ifdef TILE_JUDGE_MISCLICK_EN
        chk("misclick_over", bus.game_over, 1);
`else
        chk("misclick_ignored", bus.game_over, 0);
        chk("misclick_playing", bus.playing, 1);
`endif
        chk("misclick_kill", bus.kill, 0);
        chk("misclick_score", bus.score, 0);

        // asynchronous reset between clock edges
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_playing", bus.playing, 0);
        chk("async_rst_game_over", bus.game_over, 0);
        chk("async_rst_newNote", bus.newNote, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
